// File: rtl/ultrasonido_multicanal.sv
// Multi-channel ultrasonic ranging controller: round-robin triggering, echo width measured
// directly in cm from a 1 us tick, with timeout, saturation and a one-cycle DONE strobe.
module ultrasonido_multicanal #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int CHANNELS   = 2,
  parameter int DIST_W     = 9,
  parameter int TRIG_US    = 10,
  parameter int US_PER_CM  = 58,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 60000,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ENABLE,
  input  logic                CONTINUOUS,
  input  logic [CHANNELS-1:0] ECHO,
  output logic [CHANNELS-1:0] trigg,
  output logic [DIST_W-1:0]   d,
  output logic [CW-1:0]       chan,
  output logic                TIMEOUT,
  output logic                DONE,
  output logic                busy
);

  localparam int DIV  = CLK_HZ / 1_000_000;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TMAX = (TIMEOUT_US > GAP_US) ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                                              : ((GAP_US > TRIG_US) ? GAP_US : TRIG_US);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_US - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_US - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_US - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(US_PER_CM - 1);
  localparam logic [CW-1:0] PTR_LAST  = CW'(CHANNELS - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP} state_t;

  state_t              state, state_n;
  logic [PW-1:0]       pre;
  logic [TW-1:0]       tcnt;
  logic [CW-1:0]       ptr;
  logic                en_q;
  logic                to_hit, to_flag;
  logic                tick, enter;
  logic [CHANNELS-1:0] echo_meta_p0, echo_sync_p1;
  logic                echo_sel, echo_prev_p2, rise, fall;
  logic [SW-1:0]       sub;
  logic [DIST_W-1:0]   cm;

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign tick     = (pre == PRE_LAST);
  assign enter    = (state_n != state);
  assign echo_sel = echo_sync_p1[ptr];
  assign rise     = echo_sel & ~echo_prev_p2;
  assign fall     = ~echo_sel & echo_prev_p2;
  assign busy     = (state != IDLE);

  always_comb begin
    trigg = '0;
    if (state == TRIG) trigg[ptr] = 1'b1;
  end

  always_comb begin
    state_n = state;
    to_hit  = 1'b0;
    case (state)
      IDLE:
        if (CONTINUOUS ? ENABLE : (ENABLE && !en_q)) state_n = TRIG;
      TRIG:
        if (tick && tcnt == TRIG_LAST) state_n = WAIT_RISE;
      WAIT_RISE:
        if (rise) begin
          state_n = MEASURE;
        end else if (tick && tcnt == TO_LAST) begin
          state_n = REPORT;
          to_hit  = 1'b1;
        end
      MEASURE:
        if (fall) begin
          state_n = REPORT;
        end else if (tick && tcnt == TO_LAST) begin
          state_n = REPORT;
          to_hit  = 1'b1;
        end
      REPORT:
        state_n = GAP;
      GAP:
        if (tick && tcnt == GAP_LAST) state_n = (CONTINUOUS && ENABLE) ? TRIG : IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // Control: FSM, tick prescaler (restarted on every state entry), channel pointer, result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pre     <= '0;
      tcnt    <= '0;
      ptr     <= '0;
      en_q    <= 1'b0;
      to_flag <= 1'b0;
      DONE    <= 1'b0;
      d       <= '0;
      chan    <= '0;
      TIMEOUT <= 1'b0;
    end else begin
      state <= state_n;
      en_q  <= ENABLE;
      DONE  <= (state == REPORT);
      if (enter) begin
        pre  <= '0;
        tcnt <= '0;
      end else if (tick) begin
        pre  <= '0;
        tcnt <= tcnt + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (state_n == REPORT) to_flag <= to_hit;
      if (state == REPORT) begin
        d       <= to_flag ? '1 : cm;
        chan    <= ptr;
        TIMEOUT <= to_flag;
        ptr     <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end
    end
  end

  // p0/p1: echo synchroniser; p2: previous selected sample for edge detection
  always_ff @(posedge clk) begin
    echo_meta_p0 <= ECHO;
    echo_sync_p1 <= echo_meta_p0;
    echo_prev_p2 <= echo_sel;
  end

  // Distance accumulation: sub counts microseconds within one centimetre
  always_ff @(posedge clk) begin
    if (state != MEASURE) begin
      sub <= '0;
      cm  <= '0;
    end else if (tick) begin
      if (sub == SUB_LAST) begin
        sub <= '0;
        cm  <= sat_inc(cm);
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

endmodule
